mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Sequential controller for a shared N:1 data mux. N requesters compete for one output channel.
- Round-robin arbitration picks the winner and drives the mux select. The selected beat is captured into a one-deep registered output stage with a valid/ready handshake.
- Sits between independent producers and a single downstream consumer. Downstream sees a clean, registered stream tagged with its source index.

Parameters:
- N, 4, number of requesters (>=2)
- W, 8, data width per requester
- SRC_W, $clog2(N), width of the source index (derived; do not override)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  N  per-requester beat available
- req_data  input  N*W  packed payloads; requester i occupies bits [i*W +: W]
- req_ready  output  N  per-requester accept; at most one bit set per cycle
- out_valid  output  1  output register holds a beat
- out_data  output  W  registered payload
- out_src  output  SRC_W  index of the requester that supplied out_data
- out_ready  input  1  downstream accept

Behaviour:
- Transfer rules:
  - A beat transfers on the upstream side when req_valid[i] && req_ready[i].
  - A beat transfers on the downstream side when out_valid && out_ready.
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer ptr=0, so requester 0 has top priority.
  - Any held beat is discarded.
  - req_ready is all zero while rst=1.
- Output stage:
  - can_load = !out_valid || out_ready (combinational).
- Grant:
  - Combinational rotating priority search over req_valid, starting at index ptr, wrapping N-1 -> 0.
  - The first valid index g wins.
  - req_ready[g] = can_load. All other bits are 0.
  - If no req_valid bit is set, req_ready=0.
- Load on upstream transfer:
  - Next edge: out_data <= req_data[g], out_src <= g, out_valid <= 1.
  - ptr <= (g+1) mod N.
- Drain with no load: if out_valid && out_ready and there is no upstream transfer, out_valid <= 0 next edge. out_data and out_src hold.
- Stall: if out_valid && !out_ready, req_ready=0, and out_data, out_src and ptr hold stable.
- Latency and throughput:
  - Latency is 1 cycle from upstream transfer to out_valid.
  - Sustained throughput is 1 beat/cycle when out_ready=1.
- Fairness: with all N requesters continuously valid, grants cycle 0,1,...,N-1,0. No requester waits more than N-1 grants.
- Requester behaviour:
  - A requester may deassert req_valid before it is granted, with no side effect.
  - req_ready may depend combinationally on req_valid, so requesters must not make req_valid depend on req_ready.
- ptr changes only on an upstream transfer. Idle cycles do not rotate priority.

Optional Feature:
- Macro: MUX_RR_ARBITER_PKT_LOCK_EN
- When defined:
  - Adds ports req_last (input, N) and out_last (output, 1, registered with data; reset 0).
  - Two-state FSM: ARB and LOCK.
  - ARB: grant as above. A transfer with req_last[g]=0 moves to LOCK and records lock_idx=g.
  - LOCK: only lock_idx is eligible; other requesters get req_ready=0 even if valid.
  - A transfer with req_last[lock_idx]=1 returns to ARB and sets ptr <= lock_idx+1.
  - Reset forces ARB.
  - A single-beat packet (last=1) never enters LOCK.
- When undefined:
  - Those ports do not exist and there is no FSM.
  - Every beat is arbitrated independently.

Decomposition:
- Package mux_rr_arbiter_pkg holds:
  - the state enum (ARB, LOCK);
  - the rotating-index helper function (wrap increment mod N).
- One sub-module: rr_pick.
  - Purely combinational.
  - Inputs: req vector and ptr. Outputs: grant index and any_valid.
  - Reusable by other arbiters.
- The payload select is a plain N:1 mux inside the top module.

Test Plan:
- Reset:
  - Stimulus: assert rst with req_valid=4'b1111.
  - Required: out_valid=0, req_ready=0.
  - Then: first grant after release goes to requester 0.
- Fair rotation:
  - Stimulus: req_valid=4'b1111, out_ready=1 held, data_i=8'hA0+i.
  - Required: out_src sequence 0,1,2,3,0,1; out_data A0,A1,A2,A3,A0,A1; one beat per cycle.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while out_valid=1.
  - Required: out_data, out_src and ptr stable; req_ready=0; no beat lost or duplicated after out_ready returns.
- Sparse and skip:
  - Stimulus: only requester 2 valid, with ptr=3.
  - Required: grant 2 (wrap path), then ptr=3.
  - Stimulus: idle cycles.
  - Required: ptr unchanged.
- Reset mid-stall:
  - Stimulus: rst pulse while out_valid=1 and out_ready=0.
  - Required: next cycle out_valid=0, ptr=0, held beat gone.
- PKT_LOCK (macro defined):
  - Stimulus: requester 1 sends 3 beats with last on the 3rd, while 0 and 2 are valid.
  - Required: out_src=1,1,1 with out_last=0,0,1; then grant goes to 2.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin N:1 mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t  - packet-lock FSM states (ARB: free arbitration, LOCK: held by one source)
//   wrap_inc - rotating index increment, wraps n-1 -> 0
package mux_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Next index in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of req at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; caller qualifies the grant with its own accept condition.
//
// Ports:
//   req       [N-1:0]      candidate vector
//   ptr       [SRC_W-1:0]  index holding top priority
//   grant     [SRC_W-1:0]  winning index (0 when any_valid=0)
//   any_valid              at least one req bit set
module rr_pick #(
    parameter int N     = 4,
    parameter int SRC_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] grant,
    output logic             any_valid
);

    always_comb begin
        logic [SRC_W-1:0] idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        // Walk offsets from farthest to nearest so the nearest hit to ptr
        // is the last assignment and therefore wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = SRC_W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 mux with a one-deep registered output stage tagged by source index.
// Latency: 1 cycle from upstream accept to out_valid; 1 beat/cycle sustained.
// Backpressure: output register reloads only when empty or draining; otherwise req_ready=0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_data  [N*W-1:0]   requester i at bits [i*W +: W]
//   out_valid/out_ready   downstream handshake
//   out_data, out_src     registered payload and its requester index
// Optional (MUX_RR_ARBITER_PKT_LOCK_EN): req_last[N-1:0], out_last -- a multi-beat
// packet holds the grant on its source until the beat marked last.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int SRC_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    input  logic [N-1:0]     req_last,
    output logic             out_last,
`endif
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SRC_W-1:0] out_src,
    input  logic             out_ready
);

    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] grant;
    logic             any_valid;
    logic             can_load;
    logic             xfer;
    logic [N-1:0]     eligible;
    logic [W-1:0]     sel_data;

`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    state_t           state;
    logic [SRC_W-1:0] lock_idx;

    // While a packet is in flight only its source may compete.
    always_comb begin
        eligible = req_valid;
        if (state == LOCK) begin
            eligible = req_valid & (N'(1) << lock_idx);
        end
    end
`else
    assign eligible = req_valid;
`endif

    rr_pick #(
        .N     (N),
        .SRC_W (SRC_W)
    ) u_pick (
        .req       (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    assign can_load = !out_valid || out_ready;
    assign xfer     = any_valid && can_load && !rst;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SRC_W'(i)) begin
                sel_data = req_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
            out_last  <= 1'b0;
            state     <= ARB;
            lock_idx  <= '0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= grant;
            // In LOCK the grant is always lock_idx, so this also yields
            // lock_idx+1 when the packet closes.
            ptr       <= SRC_W'(wrap_inc(int'(grant), N));
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
            out_last  <= req_last[grant];
            if (state == ARB && !req_last[grant]) begin
                state    <= LOCK;
                lock_idx <= grant;
            end else if (state == LOCK && req_last[grant]) begin
                state    <= ARB;
            end
`endif
        end else if (out_ready) begin
            // Drain with nothing to reload; payload and tag hold.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, packet-lock
// sequence (when MUX_RR_ARBITER_PKT_LOCK_EN is defined), then randomized traffic
// against a reference model of the arbitration rules.
module tb_mux_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = $clog2(N);

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_ready;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    logic [N-1:0]   req_last;
    logic           out_last;
`endif

    mux_rr_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
        .req_last  (req_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the output register should hold and
    // which requester currently has top priority.
    int           m_ptr = 0;
    logic         m_ov  = 1'b0;
    logic [W-1:0] m_od  = '0;
    int           m_src = 0;
    logic [N-1:0] pre_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check the combinational grant against the
    // model, clock, then check the output register against the model.
    task automatic cycle(input logic r, input logic [N-1:0] v,
                         input logic [N*W-1:0] d, input logic ordy);
        int g;
        logic [N-1:0] e_rdy;
        rst       = r;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
        req_last  = '1;
`endif
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && ((v >> ((m_ptr + k) % N)) & N'(1)) != '0) g = (m_ptr + k) % N;
        end
        e_rdy = '0;
        if (!r && g >= 0 && (!m_ov || ordy)) e_rdy = N'(1) << g;
        pre_rdy = req_ready;
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
        if (r) begin
            m_ov = 1'b0; m_od = '0; m_src = 0; m_ptr = 0;
        end else if (e_rdy != '0) begin
            m_ov = 1'b1; m_od = W'(d >> (g * W)); m_src = g; m_ptr = (g + 1) % N;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_src",   32'(out_src),   32'(m_src));
        chk("out_data",  32'(out_data),  32'(m_od));
    endtask

`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
    task automatic lock_step(input logic [N-1:0] v, input logic [N-1:0] last,
                             input logic [N-1:0] e_rdy, input int e_src, input logic e_last);
        rst = 1'b0; req_valid = v; req_last = last; out_ready = 1'b1;
        #1;
        chk("lock_ready", 32'(req_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
        chk("lock_src",  32'(out_src),  32'(e_src));
        chk("lock_last", 32'(out_last), 32'(e_last));
        chk("lock_vld",  32'(out_valid), 32'(1));
    endtask
`endif

    typedef struct {
        logic         r;
        logic [N-1:0] v;
        logic         ordy;
        logic [N-1:0] e_rdy;
        logic         e_ov;
        int           e_src;
        logic [W-1:0] e_dat;
    } vec_t;

    vec_t           tbl[19];
    logic [N*W-1:0] fix_d;

    initial begin
        fix_d = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        // reset with all requesters valid
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 0, 8'h00};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 0, 8'h00};
        // fair rotation 0,1,2,3,0,1
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 8'hA0};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 8'hA1};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2, 8'hA2};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3, 8'hA3};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 8'hA0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 8'hA1};
        // backpressure 3 cycles, then requester 2 is next
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1, 8'hA1};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1, 8'hA1};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 1, 8'hA1};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2, 8'hA2};
        // ptr=3, only requester 2 valid: wrap path, ptr back to 3
        tbl[12] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 8'hA2};
        // idle: drain, payload holds, ptr stays at 3
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2, 8'hA2};
        tbl[14] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2, 8'hA2};
        tbl[15] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3, 8'hA3};
        // reset in the middle of a stall
        tbl[16] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 3, 8'hA3};
        tbl[17] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 0, 8'h00};
        tbl[18] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 0, 8'hA0};

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].r, tbl[i].v, fix_d, tbl[i].ordy);
            chk($sformatf("tbl%0d_rdy", i), 32'(pre_rdy),   32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_ov", i),  32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_src", i), 32'(out_src),   32'(tbl[i].e_src));
            chk($sformatf("tbl%0d_dat", i), 32'(out_data),  32'(tbl[i].e_dat));
        end

`ifdef MUX_RR_ARBITER_PKT_LOCK_EN
        // ptr=1 here: requester 1 sends a 3-beat packet while 0 and 2 compete.
        lock_step(4'b0111, 4'b0000, 4'b0010, 1, 1'b0);
        lock_step(4'b0111, 4'b0000, 4'b0010, 1, 1'b0);
        lock_step(4'b0111, 4'b0010, 4'b0010, 1, 1'b1);
        lock_step(4'b0111, 4'b1111, 4'b0100, 2, 1'b1);
        cycle(1'b1, 4'b0000, fix_d, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic          r;
            logic [N-1:0]  v;
            logic          ordy;
            r    = ($urandom_range(0, 39) == 0);
            v    = N'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            cycle(r, v, N*W'($urandom), ordy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
